// File: rtl/p2s_tx_if.sv
// Handshake and serial-output bundle for the parallel-to-serial transmitter.
// The master side is the upstream word source and the serial-stream observer.
// The slave side is the transmitter itself.
interface p2s_tx_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       ser_en;
    logic       ser_data;
    logic       word_done;
    logic       busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_en,
        input  ser_data,
        input  word_done,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_en,
        output ser_data,
        output word_done,
        output busy
    );
endinterface

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter.
// Accepts 4-bit words into a 2-entry FIFO. Each word is sent MSB-first as a
// 4-cycle burst. Every burst is aligned to a free-running 2-bit phase counter,
// so a receiver reset alongside this block frames each word correctly.
module p2s_tx (
    input  logic     clk,
    input  logic     rst,
    p2s_tx_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [1:0] r_phase;
    logic [3:0] r_mem [0:1];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic [3:0] r_sh;

    logic       w_ready;
    logic       w_push;
    logic       w_launch;
    logic       w_pop;

    // No bypass: a pop can only see words that were already counted before this edge.
    assign w_ready  = (r_count != 2'd2);
    assign w_push   = bus.in_valid & w_ready;
    assign w_launch = (r_phase == 2'd3);
    assign w_pop    = w_launch & (r_count != 2'd0);

    // Free-running frame phase, shared in timing with the receiver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
        end
    end

    // Two-entry FIFO storage, pointers, and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Burst state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Burst state only changes at the frame boundary: start if a word is available.
    always_comb begin
        w_state_nxt = r_state;
        if (w_launch) begin
            w_state_nxt = w_pop ? ST_BURST : ST_IDLE;
        end
    end

    // Shift register: load the head word at the frame boundary, otherwise shift out MSB-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh <= '0;
        end else if (w_launch) begin
            r_sh <= w_pop ? r_mem[r_rd_ptr] : 4'd0;
        end else if (r_state == ST_BURST) begin
            r_sh <= {r_sh[2:0], 1'b0};
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.ser_en    = (r_state == ST_BURST);
    assign bus.ser_data  = r_sh[3];
    assign bus.word_done = (r_state == ST_BURST) && (r_phase == 2'd3);
    assign bus.busy      = (r_state == ST_BURST) || (r_count != 2'd0);

endmodule

// File: tb/tb_p2s_tx.sv
module tb_p2s_tx;

    logic clk;
    logic rst;

    p2s_tx_if bus();

    p2s_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int unsigned phase_m;
    int unsigned m_count;
    bit          m_en;
    logic [3:0]  cur_word;
    bit          last_hs;
    logic [3:0]  sb[$];

    // Receiver-side observation
    logic [3:0]  acc;
    logic [3:0]  rx_log[$];
    int          run_len;
    int          max_run;

    task automatic model_reset();
        phase_m  = 0;
        m_count  = 0;
        m_en     = 1'b0;
        cur_word = 4'd0;
        last_hs  = 1'b0;
        sb.delete();
        acc      = 4'd0;
        run_len  = 0;
    endtask

    // One clock cycle: advance the model across the edge, then check DUT outputs.
    task automatic tick();
        bit          hs;
        bit          pop;
        logic [3:0]  d;
        logic        exp_sd;
        int unsigned bi;
        hs = bus.in_valid && (m_count != 2);
        d  = bus.in_data;
        @(posedge clk);
        pop = (phase_m == 3) && (m_count > 0);
        if (phase_m == 3) begin
            m_en = pop;
            if (pop) cur_word = sb.pop_front();
        end
        if (hs) sb.push_back(d);
        m_count = m_count + (hs ? 1 : 0) - (pop ? 1 : 0);
        phase_m = (phase_m + 1) % 4;
        last_hs = hs;
        @(negedge clk);

        tests++;
        if (bus.ser_en !== m_en) begin
            fails++;
            $display("FAIL ser_en phase=%0d got=%b exp=%b t=%0t", phase_m, bus.ser_en, m_en, $time);
        end
        tests++;
        if (bus.in_ready !== (m_count != 2)) begin
            fails++;
            $display("FAIL in_ready phase=%0d got=%b exp=%b t=%0t", phase_m, bus.in_ready, (m_count != 2), $time);
        end
        tests++;
        if (bus.busy !== (m_en || m_count != 0)) begin
            fails++;
            $display("FAIL busy phase=%0d got=%b exp=%b t=%0t", phase_m, bus.busy, (m_en || m_count != 0), $time);
        end
        tests++;
        if (bus.word_done !== (m_en && phase_m == 3)) begin
            fails++;
            $display("FAIL word_done phase=%0d got=%b exp=%b t=%0t", phase_m, bus.word_done, (m_en && phase_m == 3), $time);
        end
        bi = 3 - phase_m;
        exp_sd = m_en ? cur_word[bi[1:0]] : 1'b0;
        tests++;
        if (bus.ser_data !== exp_sd) begin
            fails++;
            $display("FAIL ser_data phase=%0d got=%b exp=%b t=%0t", phase_m, bus.ser_data, exp_sd, $time);
        end

        if (bus.ser_en === 1'b1) begin
            acc = {acc[2:0], bus.ser_data};
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (m_en && phase_m == 3) rx_log.push_back(acc);
    endtask

    task automatic wait_phase(input int unsigned p);
        for (int k = 0; k < 4 && phase_m != p; k++) tick();
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
        repeat (3) @(negedge clk);
        tests++;
        if (bus.ser_en !== 1'b0) begin fails++; $display("FAIL reset_ser_en got=%b exp=0", bus.ser_en); end
        tests++;
        if (bus.ser_data !== 1'b0) begin fails++; $display("FAIL reset_ser_data got=%b exp=0", bus.ser_data); end
        tests++;
        if (bus.word_done !== 1'b0) begin fails++; $display("FAIL reset_word_done got=%b exp=0", bus.word_done); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        model_reset();
        rst = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_single();
        drain();
        rx_log.delete();
        wait_phase(1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1011;
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        tests++;
        if (rx_log.size() != 1 || rx_log[0] !== 4'b1011) begin
            fails++;
            $display("FAIL single_word got_count=%0d got=%h exp=b", rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 4'hx);
        end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL single_busy_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [4];
        int         i;
        int         blocked_at;
        words = '{4'hA, 4'h5, 4'hF, 4'h0};
        drain();
        wait_phase(0);
        rx_log.delete();
        max_run    = 0;
        run_len    = 0;
        i          = 0;
        blocked_at = -1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 40 && i < 4; c++) begin
            bus.in_data = words[i];
            tick();
            if (last_hs) i++;
            if (bus.in_ready === 1'b0 && blocked_at < 0) blocked_at = i;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (i != 4) begin fails++; $display("FAIL b2b_accepts got=%0d exp=4", i); end
        tests++;
        if (blocked_at != 2) begin fails++; $display("FAIL b2b_ready_drop accepts_before_drop got=%0d exp=2", blocked_at); end
        drain();
        tests++;
        if (max_run != 16) begin fails++; $display("FAIL b2b_ser_en_run got=%0d exp=16", max_run); end
        tests++;
        if (rx_log.size() != 4) begin
            fails++;
            $display("FAIL b2b_word_count got=%0d exp=4", rx_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (rx_log[k] !== words[k]) begin
                    fails++;
                    $display("FAIL b2b_word%0d got=%h exp=%h", k, rx_log[k], words[k]);
                end
            end
        end
    endtask

    task automatic test_late_push();
        logic [3:0] w;
        w = 4'h6;
        drain();
        wait_phase(3);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            tests++;
            if (bus.ser_en !== 1'b0) begin fails++; $display("FAIL late_idle cycle=%0d got=%b exp=0", k, bus.ser_en); end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (bus.ser_en !== 1'b1 || bus.ser_data !== w[3-k]) begin
                fails++;
                $display("FAIL late_burst bit=%0d got_en=%b got_data=%b exp_en=1 exp_data=%b", k, bus.ser_en, bus.ser_data, w[3-k]);
            end
        end
    endtask

    task automatic test_push_pop();
        drain();
        rx_log.delete();
        wait_phase(1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h9;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h3;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.ser_en !== 1'b1) begin
            fails++;
            $display("FAIL pushpop_after_edge got_ready=%b got_en=%b exp_ready=1 exp_en=1", bus.in_ready, bus.ser_en);
        end
        repeat (10) tick();
        tests++;
        if (rx_log.size() != 2 || rx_log[0] !== 4'h9 || rx_log[1] !== 4'h3) begin
            fails++;
            $display("FAIL pushpop_words got_count=%0d exp=9,3", rx_log.size());
        end
    endtask

    task automatic test_reset_mid();
        drain();
        wait_phase(1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hC;
        tick();
        bus.in_data  = 4'hD;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        tests++;
        if (bus.ser_en !== 1'b1 || phase_m != 2 || m_count != 1) begin
            fails++;
            $display("FAIL rstmid_setup got_en=%b exp_en=1", bus.ser_en);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.ser_en !== 1'b0) begin fails++; $display("FAIL rstmid_ser_en got=%b exp=0", bus.ser_en); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_log.delete();
        repeat (12) tick();
        tests++;
        if (rx_log.size() != 0) begin fails++; $display("FAIL rstmid_no_tx got_count=%0d exp=0", rx_log.size()); end
    endtask

    initial begin
        model_reset();
        max_run = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_late_push();
        test_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
